// File: rtl/hex_scroll_sequencer.sv
// Timed scroller for a 5-character message expanded to an 8-slot ring, feeding the
// HEX character-decode stage with rotated 3-bit codes.
module hex_scroll_sequencer #(
  parameter int unsigned TICK_DIV = 50000000
) (
  input  logic       CLOCK_50,
  input  logic       reset,
  input  logic       load,
  input  logic [2:0] u,
  input  logic [2:0] v,
  input  logic [2:0] w,
  input  logic [2:0] x,
  input  logic [2:0] y,
  input  logic       en,
  input  logic       dir,
  input  logic       step,
  output logic [2:0] m7,
  output logic [2:0] m6,
  output logic [2:0] m5,
  output logic [2:0] m4,
  output logic [2:0] m3,
  output logic [2:0] m2,
  output logic [2:0] m1,
  output logic [2:0] m0,
  output logic [2:0] pos,
  output logic [1:0] state,
  output logic       tick
);

  localparam int unsigned CntW = $clog2(TICK_DIV);
  localparam logic [CntW-1:0] CntMax = CntW'(TICK_DIV - 1);

  typedef enum logic [1:0] {
    StBlank = 2'b00,
    StRun   = 2'b01,
    StHold  = 2'b10
  } state_e;

  state_e          state_q, state_d;
  logic [2:0]      ring_q [8];
  logic [2:0]      pos_q;
  logic [CntW-1:0] cnt_q;
  logic            tick_q;
  logic            step_q;
  logic            step_edge_q;
  logic [2:0]      pos_adv;
  logic            wrap;
  logic [2:0]      disp [8];

  assign pos_adv = dir ? (pos_q - 3'd1) : (pos_q + 3'd1);
  assign wrap    = (state_q == StRun) && (cnt_q == CntMax);

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      state_q <= StBlank;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (load) begin
      state_d = en ? StRun : StHold;
    end else if (state_q != StBlank) begin
      state_d = en ? StRun : StHold;
    end
  end

  // Step edge is registered before use, so a manual advance lands one cycle after sampling.
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      for (int i = 0; i < 8; i++) ring_q[i] <= 3'b111;
      pos_q       <= 3'd0;
      cnt_q       <= '0;
      tick_q      <= 1'b0;
      step_q      <= 1'b0;
      step_edge_q <= 1'b0;
    end else begin
      step_q      <= step;
      step_edge_q <= step & ~step_q;
      tick_q      <= 1'b0;
      if (load) begin
        ring_q[0] <= u;
        ring_q[1] <= v;
        ring_q[2] <= w;
        ring_q[3] <= w;
        ring_q[4] <= x;
        ring_q[5] <= y;
        ring_q[6] <= y;
        ring_q[7] <= y;
        pos_q     <= 3'd0;
        cnt_q     <= '0;
      end else if (state_q == StRun) begin
        if (wrap) begin
          cnt_q  <= '0;
          tick_q <= 1'b1;
          pos_q  <= pos_adv;
        end else begin
          cnt_q <= cnt_q + 1'b1;
        end
      end else if (state_q == StHold && step_edge_q) begin
        pos_q <= pos_adv;
      end
    end
  end

  always_comb begin
    for (int i = 0; i < 8; i++) begin
      disp[i] = (state_q == StBlank) ? 3'b111 : ring_q[pos_q + 3'(i)];
    end
  end

  assign m7    = disp[0];
  assign m6    = disp[1];
  assign m5    = disp[2];
  assign m4    = disp[3];
  assign m3    = disp[4];
  assign m2    = disp[5];
  assign m1    = disp[6];
  assign m0    = disp[7];
  assign pos   = pos_q;
  assign state = state_q;
  assign tick  = tick_q;

endmodule

// File: tb/tb_hex_scroll_sequencer.sv
// Randomized and directed bench for hex_scroll_sequencer against a cycle-level message model.
module tb_hex_scroll_sequencer;

  localparam int TD = 4;

  logic       CLOCK_50 = 1'b0;
  logic       reset, load, en, dir, step;
  logic [2:0] u, v, w, x, y;
  logic [2:0] m7, m6, m5, m4, m3, m2, m1, m0, pos;
  logic [1:0] state;
  logic       tick;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: message ring, rotation index, phase within the tick period.
  int mr [8];
  int mpos, mcnt, mst;
  bit mtick, mstepq, mpend;

  hex_scroll_sequencer #(.TICK_DIV(TD)) dut (
    .CLOCK_50(CLOCK_50), .reset(reset), .load(load),
    .u(u), .v(v), .w(w), .x(x), .y(y),
    .en(en), .dir(dir), .step(step),
    .m7(m7), .m6(m6), .m5(m5), .m4(m4), .m3(m3), .m2(m2), .m1(m1), .m0(m0),
    .pos(pos), .state(state), .tick(tick)
  );

  always #5 CLOCK_50 = ~CLOCK_50;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic int advanced(input int p, input bit d);
    return d ? (p + 7) % 8 : (p + 1) % 8;
  endfunction

  function automatic logic [23:0] model_disp();
    logic [23:0] r = '0;
    for (int i = 0; i < 8; i++) begin
      r[23-3*i -: 3] = (mst == 0) ? 3'b111 : 3'(mr[(mpos + i) % 8]);
    end
    return r;
  endfunction

  task automatic model_update();
    bit edge_now = step && !mstepq;
    if (reset) begin
      for (int i = 0; i < 8; i++) mr[i] = 7;
      mpos = 0; mcnt = 0; mst = 0; mtick = 0; mstepq = 0; mpend = 0;
    end else begin
      mtick = 0;
      if (load) begin
        mr = '{int'(u), int'(v), int'(w), int'(w), int'(x), int'(y), int'(y), int'(y)};
        mpos = 0;
        mcnt = 0;
        mst  = en ? 1 : 2;
      end else if (mst == 1) begin
        mcnt++;
        if (mcnt == TD) begin
          mcnt  = 0;
          mtick = 1;
          mpos  = advanced(mpos, dir);
        end
        if (!en) mst = 2;
      end else if (mst == 2) begin
        if (mpend) mpos = advanced(mpos, dir);
        if (en) mst = 1;
      end
      mpend  = edge_now;
      mstepq = step;
    end
  endtask

  task automatic compare_all();
    check("m", {m7, m6, m5, m4, m3, m2, m1, m0}, model_disp());
    check("pos", pos, mpos);
    check("state", state, mst);
    check("tick", tick, mtick);
  endtask

  task automatic cycle();
    @(posedge CLOCK_50);
    model_update();
    @(negedge CLOCK_50);
    compare_all();
  endtask

  task automatic do_load(input logic [2:0] a, b, c, d, e, input bit en_v, dir_v);
    {u, v, w, x, y} = {a, b, c, d, e};
    en = en_v; dir = dir_v; load = 1'b1;
    cycle();
    load = 1'b0;
  endtask

  initial begin
    int last, nticks;
    reset = 1'b1; load = 1'b0; en = 1'b0; dir = 1'b0; step = 1'b0;
    {u, v, w, x, y} = '0;
    cycle(); cycle();
    check("rst_m", {m7, m6, m5, m4, m3, m2, m1, m0}, 24'hFFFFFF);
    check("rst_pos", pos, 3'd0);
    check("rst_state", state, 2'b00);
    check("rst_tick", tick, 1'b0);
    reset = 1'b0;

    // HELLO, auto-scroll left
    do_load(3'd0, 3'd1, 3'd2, 3'd3, 3'd7, 1'b1, 1'b0);
    check("load_m", {m7, m6, m5, m4, m3, m2, m1, m0}, 24'b000_001_010_010_011_111_111_111);
    check("load_state", state, 2'b01);
    for (int i = 0; i < 3; i++) cycle();
    check("pre_tick", tick, 1'b0);
    cycle();
    check("first_tick", tick, 1'b1);
    check("first_pos", pos, 3'd1);
    check("first_m7", m7, 3'd1);
    check("first_m0", m0, 3'd0);

    last = 0; nticks = 0;
    for (int c = 1; c <= 32; c++) begin
      cycle();
      if (tick) begin
        nticks++;
        check("tick_gap", c - last, 4);
        last = c;
      end
    end
    check("tick_count", nticks, 8);
    check("wrap_m", {m7, m6, m5, m4, m3, m2, m1, m0}, 24'b001_010_010_011_111_111_111_000);

    // Pause with prescaler at 2, three manual steps, resume
    cycle();
    en = 1'b0;
    cycle();
    check("hold_state", state, 2'b10);
    for (int i = 0; i < 3; i++) begin
      step = 1'b1; cycle();
      step = 1'b0; cycle();
    end
    cycle();
    check("step_pos", pos, 3'd4);
    en = 1'b1;
    cycle();
    cycle();
    check("resume_tick0", tick, 1'b0);
    cycle();
    check("resume_tick1", tick, 1'b1);
    check("resume_pos", pos, 3'd5);

    // Scroll right from 0
    do_load(3'd0, 3'd1, 3'd2, 3'd3, 3'd7, 1'b1, 1'b1);
    for (int i = 0; i < 4; i++) cycle();
    check("right_pos", pos, 3'd7);
    check("right_m7", m7, 3'b111);
    check("right_m6", m6, 3'd0);

    // Load colliding with a wrap
    for (int i = 0; i < 3; i++) cycle();
    do_load(3'd3, 3'd2, 3'd1, 3'd0, 3'd4, 1'b1, 1'b0);
    check("ldwrap_tick", tick, 1'b0);
    check("ldwrap_pos", pos, 3'd0);
    for (int i = 0; i < 4; i++) cycle();
    check("ldwrap_next", tick, 1'b1);

    // Reset mid-scroll at pos 5, then inputs ignored until load
    for (int i = 0; i < 40 && mpos != 5; i++) cycle();
    check("reach_pos5", pos, 3'd5);
    reset = 1'b1;
    cycle();
    reset = 1'b0;
    check("mid_rst_m", {m7, m6, m5, m4, m3, m2, m1, m0}, 24'hFFFFFF);
    check("mid_rst_pos", pos, 3'd0);
    check("mid_rst_state", state, 2'b00);
    for (int i = 0; i < 10; i++) begin
      en = 1'($urandom_range(0, 1)); step = ~step;
      cycle();
      check("blank_state", state, 2'b00);
    end

    // Random traffic
    for (int i = 0; i < 1500; i++) begin
      reset = ($urandom_range(0, 99) == 0);
      load  = ($urandom_range(0, 19) == 0);
      if ($urandom_range(0, 9) == 0) en = ~en;
      if ($urandom_range(0, 15) == 0) dir = ~dir;
      step = 1'($urandom_range(0, 1));
      {u, v, w, x, y} = 15'($urandom);
      cycle();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
